// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port CPU data memory.
// Bounded bursts per port, one access per cycle, registered read response.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int unsigned CntW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(BURST_MAX);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    // owner_q: 1 selects port 1
    logic            owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gnt0, gnt1;
    logic            rd0, rd1;

    logic              rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

    // Grants are forced low while reset is held so nothing reaches memory.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                if ((cnt_q != '0) && (cnt_q < CntMax)) begin
                    gnt0 = ~owner_q;
                    gnt1 = owner_q;
                end else begin
                    gnt0 = owner_q;
                    gnt1 = ~owner_q;
                end
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = '0;
        if (gnt0 || gnt1) begin
            if (gnt1 == owner_q) begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
            end else begin
                owner_d = gnt1;
                cnt_d   = CntOne;
            end
        end
    end

    always_comb begin
        mem_addr  = gnt1 ? req1_addr  : req0_addr;
        mem_wdata = gnt1 ? req1_wdata : req0_wdata;
        mem_we    = (gnt0 && req0_we) || (gnt1 && req1_we);
        rd0       = gnt0 && !req0_we;
        rd1       = gnt1 && !req1_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b1;
            cnt_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rsp0_valid_q <= rd0;
            rsp1_valid_q <= rd1;
            if (rd0) begin
                rsp0_rdata_q <= mem_rd;
            end
            if (rd1) begin
                rsp1_rdata_q <= mem_rd;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, grant-history reference model,
// directed scenarios followed by a randomized phase.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 32;
    localparam int          BURST_MAX = 4;
    localparam int          DEPTH     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req0_we, rsp0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, rsp1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata, mem_rd;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_we   (req0_we),
        .req0_addr (req0_addr),
        .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_we   (req1_we),
        .req1_addr (req1_addr),
        .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return (i == 0) ? 32'd49 : ((i * 32'h0101_0101) ^ 32'hA5A5_0000);
    endfunction

    // Stand-in for cpu_memory: combinational read, write on rising edge.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              init_mem;
    assign mem_rd = mem[mem_addr];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model: memory contents, grant history since reset, expected responses.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                hist[$];
    logic              exp_rv0, exp_rv1;
    logic [DATA_W-1:0] exp_rd0, exp_rd1;
    int                checks = 0;
    int                errors = 0;
    int                last_g;

    function automatic int model_owner();
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] != -1) return hist[k];
        end
        return 1;
    endfunction

    // Length of the unbroken run of grants to the owner ending last cycle, capped.
    function automatic int model_streak();
        int o;
        int n;
        o = model_owner();
        n = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] != o) break;
            n++;
        end
        return (n > BURST_MAX) ? BURST_MAX : n;
    endfunction

    function automatic int model_grant(input logic v0, input logic v1);
        int o;
        int s;
        o = model_owner();
        s = model_streak();
        if (v0 && v1) return (s > 0 && s < BURST_MAX) ? o : 1 - o;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rsp();
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
    endtask

    // One clock cycle: drive at falling edge, check, then advance the model at the rising edge.
    task automatic cyc(input logic rst, input logic mid_rst,
                       input logic v0, input logic we0, input logic [ADDR_W-1:0] a0,
                       input logic [DATA_W-1:0] d0,
                       input logic v1, input logic we1, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d1);
        int g;
        @(negedge clk);
        rst_n      = rst;
        req0_valid = v0;
        req0_we    = we0;
        req0_addr  = a0;
        req0_wdata = d0;
        req1_valid = v1;
        req1_we    = we1;
        req1_addr  = a1;
        req1_wdata = d1;
        if (!rst) clear_rsp();
        #1;
        g = rst ? model_grant(v0, v1) : -1;
        chk("ready0", req0_ready, (g == 0));
        chk("ready1", req1_ready, (g == 1));
        chk("mem_we", mem_we, (g == 0) ? we0 : (g == 1) ? we1 : 1'b0);
        chk("mem_addr", mem_addr, (g == 1) ? a1 : a0);
        chk("mem_wdata", mem_wdata, (g == 1) ? d1 : d0);
        chk("rsp0_valid", rsp0_valid, exp_rv0);
        chk("rsp1_valid", rsp1_valid, exp_rv1);
        chk("rsp0_rdata", rsp0_rdata, exp_rd0);
        chk("rsp1_rdata", rsp1_rdata, exp_rd1);
        if (mid_rst) begin
            rst_n = 1'b0;
            #1;
            clear_rsp();
            g = -1;
            chk("rst_ready0", req0_ready, 1'b0);
            chk("rst_ready1", req1_ready, 1'b0);
            chk("rst_mem_we", mem_we, 1'b0);
            chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        end
        last_g = g;
        @(posedge clk);
        if (!rst_n) begin
            hist.delete();
        end else begin
            hist.push_back(g);
            exp_rv0 = 1'b0;
            exp_rv1 = 1'b0;
            if (g == 0 && !we0) begin
                exp_rv0 = 1'b1;
                exp_rd0 = ref_mem[a0];
            end
            if (g == 1 && !we1) begin
                exp_rv1 = 1'b1;
                exp_rd1 = ref_mem[a1];
            end
            if (g == 0 && we0) ref_mem[a0] = d0;
            if (g == 1 && we1) ref_mem[a1] = d1;
        end
    endtask

    task automatic idle(input logic rst);
        cyc(rst, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int run;
        int prev;
        logic v0, v1, we0, we1, r;
        init_mem = 1'b1;
        rst_n    = 1'b0;
        clear_rsp();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        // Reset state
        idle(1'b0);
        idle(1'b0);
        init_mem = 1'b0;
        idle(1'b0);

        // 1: first contention after reset goes to port 0; word 0 reads back 49
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd0, '0, 1'b1, 1'b0, 10'd1, '0);
        chk("t1_first_grant_p0", req0_ready, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        chk("t1_rsp0_valid", rsp0_valid, 1'b1);
        chk("t1_rsp0_rdata", rsp0_rdata, 32'd49);

        // 2: continuous contention, bursts bounded at BURST_MAX
        run = 0;
        prev = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'(i), '0, 1'b1, 1'b0, 10'(i + 100), '0);
            run = (last_g == prev) ? run + 1 : 1;
            prev = last_g;
            chk("t2_burst_bound", (run <= BURST_MAX), 1'b1);
        end
        idle(1'b1);

        // 3: port 1 alone never stalls; port 0 joins against a saturated burst
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'(i + 20), '0);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd3, '0, 1'b1, 1'b0, 10'd4, '0);
        chk("t3_p0_immediate", req0_ready, 1'b1);
        idle(1'b1);

        // 4: port 0 write then port 1 read-after-write
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd5, '0);
        idle(1'b1);
        chk("t4_rsp1_rdata", rsp1_rdata, 32'hDEAD_BEEF);
        chk("t4_rsp0_quiet", rsp0_valid, 1'b0);

        // 5: reset lands while a port 1 read is granted
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd7, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd7, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd8, '0, 1'b1, 1'b0, 10'd9, '0);
        chk("t5_p0_wins", req0_ready, 1'b1);
        idle(1'b1);

        // 6: alternating single requests with idle gaps
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'(i), '0, 1'b0, 1'b0, '0, '0);
            else            cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'(i), '0);
            idle(1'b1);
        end

        // Randomized traffic over a small address window to exercise read-after-write
        for (int i = 0; i < 600; i++) begin
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 3) != 0);
            we0 = $urandom_range(0, 1) == 1;
            we1 = $urandom_range(0, 1) == 1;
            r   = ($urandom_range(0, 63) != 0);
            cyc(r, 1'b0, v0, we0, 10'($urandom_range(0, 15)), $urandom,
                v1, we1, 10'($urandom_range(0, 15)), $urandom);
        end
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
